udp_logic_arbiter: RTL and testbench

- Shares one bitwise 8-function logic unit (NOT/BUF/AND/OR/XOR/NAND/NOR/XNOR) among NREQ requesters.
- Round-robin arbitration grants at most one operation per cycle.
- The result is registered and returned on a single response channel tagged with the requester ID, under valid/ready backpressure.
- Sits between cosim stimulus agents and the shared primitive-logic datapath.

---
 rtl/udp_logic_pkg.sv | 29 ++
 rtl/udp_logic_unit.sv | 25 ++
 rtl/udp_logic_arbiter.sv | 80 ++++++++
 tb/tb_udp_logic_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/udp_logic_pkg.sv
// udp_logic_pkg: opcode encoding and reference semantics for the shared bitwise logic unit.
package udp_logic_pkg;
    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_BUF  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_XNOR = 3'd7
    } logic_op_t;

    localparam int MAXW = 64;

    // Evaluated at MAXW bits; callers keep the low WIDTH bits.
    function automatic logic [MAXW-1:0] logic_apply(logic_op_t op, logic [MAXW-1:0] a, logic [MAXW-1:0] b);
        case (op)
            OP_NOT:  return ~a;
            OP_BUF:  return a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction
endpackage

// File: rtl/udp_logic_unit.sv
// udp_logic_unit: combinational bitwise NOT/BUF/AND/OR/XOR/NAND/NOR/XNOR over WIDTH bits.
module udp_logic_unit
    import udp_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic_op_t          op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   y
);
    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_BUF:  y = a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
        endcase
    end
endmodule

// File: rtl/udp_logic_arbiter.sv
// udp_logic_arbiter: round-robin sharing of one logic unit among NREQ requesters,
// with a single registered, id-tagged response slot under valid/ready backpressure.
module udp_logic_arbiter
    import udp_logic_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*3-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data
);
    logic             can_issue, found, xfer;
    logic [IDW-1:0]   last_gnt, gnt_id, idx;
    logic_op_t        op_sel;
    logic [WIDTH-1:0] a_sel, b_sel, res;

    assign can_issue = !rsp_valid || rsp_ready;
    assign xfer      = |req_ready;

    // Scan from the requester after the last winner, wrapping mod NREQ.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_gnt) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        req_ready = (can_issue && found && !rst) ? (NREQ'(1) << gnt_id) : '0;
    end

    always_comb begin
        op_sel = OP_NOT;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                op_sel = logic_op_t'(req_op[3*i +: 3]);
                a_sel  = req_a[WIDTH*i +: WIDTH];
                b_sel  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    udp_logic_unit #(.WIDTH(WIDTH)) u_unit (
        .op (op_sel),
        .a  (a_sel),
        .b  (b_sel),
        .y  (res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            last_gnt  <= IDW'(NREQ - 1);
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_id;
            rsp_data  <= res;
            last_gnt  <= gnt_id;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_udp_logic_arbiter.sv
// tb_udp_logic_arbiter: directed vectors with hand-computed results for the shared logic arbiter.
module tb_udp_logic_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*3-1:0]     req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t sweep[8];
    logic [7:0] rr_exp[4];

    udp_logic_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3]     = op;
        req_a[WIDTH*i +: WIDTH] = a;
        req_b[WIDTH*i +: WIDTH] = b;
    endtask

    task automatic chk_rsp(input string name, input logic v, input logic [1:0] id, input logic [7:0] d);
        chk({name, ".valid"}, 32'(rsp_valid), 32'(v));
        chk({name, ".id"}, 32'(rsp_id), 32'(id));
        chk({name, ".data"}, 32'(rsp_data), 32'(d));
    endtask

    initial begin
        sweep[0] = '{3'd0, 8'hA5, 8'h0F, 8'h5A};
        sweep[1] = '{3'd1, 8'hA5, 8'h0F, 8'hA5};
        sweep[2] = '{3'd2, 8'hA5, 8'h0F, 8'h05};
        sweep[3] = '{3'd3, 8'hA5, 8'h0F, 8'hAF};
        sweep[4] = '{3'd4, 8'hA5, 8'h0F, 8'hAA};
        sweep[5] = '{3'd5, 8'hA5, 8'h0F, 8'hFA};
        sweep[6] = '{3'd6, 8'hA5, 8'h0F, 8'h50};
        sweep[7] = '{3'd7, 8'hA5, 8'h0F, 8'h55};
        rr_exp = '{8'h30, 8'hAF, 8'hAA, 8'h50};

        rst = 1'b1;
        req_valid = 4'b1111;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        step();
        step();
        chk("reset.ready", 32'(req_ready), 32'h0);
        chk_rsp("reset", 1'b0, 2'd0, 8'h00);

        // single request right after reset
        rst = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 3'd2, 8'hF0, 8'h3C);
        #1;
        chk("single.ready", 32'(req_ready), 32'h1);
        step();
        chk_rsp("single", 1'b1, 2'd0, 8'h30);

        // opcode sweep on requester 2, one result per cycle
        req_valid = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            set_req(2, sweep[i].op, sweep[i].a, sweep[i].b);
            #1;
            chk($sformatf("sweep%0d.ready", i), 32'(req_ready), 32'h4);
            step();
            chk_rsp($sformatf("sweep%0d", i), 1'b1, 2'd2, sweep[i].exp);
        end

        // pointer hold: grant 3, idle, then 3 and 0 both valid -> 0 wins
        req_valid = 4'b1000;
        set_req(3, 3'd1, 8'h3C, 8'h00);
        #1;
        chk("hold.ready3", 32'(req_ready), 32'h8);
        step();
        chk_rsp("hold.g3", 1'b1, 2'd3, 8'h3C);
        req_valid = 4'b0000;
        step();
        chk_rsp("hold.idle1", 1'b0, 2'd3, 8'h3C);
        step();
        chk_rsp("hold.idle2", 1'b0, 2'd3, 8'h3C);
        req_valid = 4'b1001;
        set_req(0, 3'd3, 8'h11, 8'h22);
        #1;
        chk("hold.wrap", 32'(req_ready), 32'h1);
        step();
        chk_rsp("hold.g0", 1'b1, 2'd0, 8'h33);

        // backpressure: pending response stalls grants for 3 cycles
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        set_req(1, 3'd2, 8'hFF, 8'h5A);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d.ready", c), 32'(req_ready), 32'h0);
            step();
            chk_rsp($sformatf("bp%0d", c), 1'b1, 2'd0, 8'h33);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.release", 32'(req_ready), 32'h2);
        step();
        chk_rsp("bp.g1", 1'b1, 2'd1, 8'h5A);

        // reset mid-stream with a pending response and all requesters valid
        set_req(0, 3'd2, 8'hF0, 8'h3C);
        set_req(1, 3'd3, 8'hA5, 8'h0F);
        set_req(2, 3'd4, 8'hA5, 8'h0F);
        set_req(3, 3'd6, 8'hA5, 8'h0F);
        req_valid = 4'b1111;
        rst = 1'b1;
        #1;
        chk("mid.rst.ready", 32'(req_ready), 32'h0);
        step();
        chk("mid.rst.valid", 32'(rsp_valid), 32'h0);
        chk("mid.rst.ready2", 32'(req_ready), 32'h0);
        rst = 1'b0;

        // round robin from reset: 0,1,2,3,0,1,2,3
        for (int n = 0; n < 8; n++) begin
            #1;
            chk($sformatf("rr%0d.ready", n), 32'(req_ready), 32'(1 << (n % 4)));
            step();
            chk_rsp($sformatf("rr%0d", n), 1'b1, 2'(n % 4), rr_exp[n % 4]);
        end

        req_valid = 4'b0000;
        step();
        chk("final.drain", 32'(rsp_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
